// File: rtl/branch_predictor_if.sv
// Branch predictor interface: fetch-side lookup and EX-side resolve/train signals.
// The pipeline drives through the master modport; the predictor uses the slave modport.
interface branch_predictor_if;
    // Fetch-side lookup
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_next_pc;

    // Execute-side resolve and training
    logic        ex_br_valid;
    logic        ex_stall;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;

    // Misprediction recovery
    logic        mispredict;
    logic [31:0] redirect_pc;

    modport master (
        output if_pc,
        input  if_pred_taken,
        input  if_next_pc,
        output ex_br_valid,
        output ex_stall,
        output ex_pc,
        output ex_taken,
        output ex_target,
        output ex_pred_taken,
        output ex_pred_target,
        input  mispredict,
        input  redirect_pc
    );

    modport slave (
        input  if_pc,
        output if_pred_taken,
        output if_next_pc,
        input  ex_br_valid,
        input  ex_stall,
        input  ex_pc,
        input  ex_taken,
        input  ex_target,
        input  ex_pred_taken,
        input  ex_pred_target,
        output mispredict,
        output redirect_pc
    );
endinterface

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped table of 2-bit saturating counters
// with a tagged target per entry. Lookup is combinational on the fetch PC;
// training happens on the clock edge from the resolving branch in EX.
// Optional macro BP_PERF_EN adds perf_branches / perf_mispredicts counters.
module branch_predictor #(
    parameter int ENTRIES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_predictor_if.slave     bp
`ifdef BP_PERF_EN
    ,
    output logic [31:0]           perf_branches,
    output logic [31:0]           perf_mispredicts
`endif
);

    // Index width is derived from the table size and must not be overridden.
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    // Table storage; valid and counters need a full clear on reset, so these
    // are flops rather than block RAM.
    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic             upd;
    logic [1:0]       ctr_d;

    assign if_idx = bp.if_pc[IDX_W+1:2];
    assign if_tag = bp.if_pc[31:IDX_W+2];
    assign ex_idx = bp.ex_pc[IDX_W+1:2];
    assign ex_tag = bp.ex_pc[31:IDX_W+2];

    // Fetch lookup: reads the pre-update table contents (no write bypass).
    always_comb begin
        if_hit           = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        bp.if_pred_taken = if_hit && ctr_q[if_idx][1];
        bp.if_next_pc    = bp.if_pred_taken ? target_q[if_idx] : (bp.if_pc + 32'd4);
    end

    // Resolve: a stalled EX neither trains nor redirects.
    always_comb begin
        upd            = bp.ex_br_valid && !bp.ex_stall;
        bp.mispredict  = upd && ((bp.ex_taken != bp.ex_pred_taken) ||
                                 (bp.ex_taken && (bp.ex_target != bp.ex_pred_target)));
        bp.redirect_pc = bp.ex_taken ? bp.ex_target : (bp.ex_pc + 32'd4);
    end

    // Saturating counter step for the entry being trained.
    always_comb begin
        ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        ctr_d  = ctr_q[ex_idx];
        if (bp.ex_taken) begin
            if (ctr_q[ex_idx] != 2'b11) ctr_d = ctr_q[ex_idx] + 2'd1;
        end else begin
            if (ctr_q[ex_idx] != 2'b00) ctr_d = ctr_q[ex_idx] - 2'd1;
        end
    end

    // Table training; reset wins over any same-cycle update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (upd) begin
            if (ex_hit) begin
                ctr_q[ex_idx] <= ctr_d;
                if (bp.ex_taken) target_q[ex_idx] <= bp.ex_target;
            end else if (bp.ex_taken) begin
                // Allocate, evicting whatever aliased into this slot.
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= bp.ex_target;
                ctr_q[ex_idx]    <= 2'b10;
            end
        end
    end

`ifdef BP_PERF_EN
    logic [31:0] perf_branches_q;
    logic [31:0] perf_mispredicts_q;

    // Event counters for resolved branches and mispredictions, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_branches_q    <= 32'd0;
            perf_mispredicts_q <= 32'd0;
        end else begin
            if (upd)           perf_branches_q    <= perf_branches_q + 32'd1;
            if (bp.mispredict) perf_mispredicts_q <= perf_mispredicts_q + 32'd1;
        end
    end

    assign perf_branches    = perf_branches_q;
    assign perf_mispredicts = perf_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: the driver applies one directed vector
// per cycle and queues its expected outputs; a monitor on the falling edge pops
// and compares. Build with +define+BP_PERF_EN to also check the perf counters.
module tb_branch_predictor;

    logic clk;
    logic rst;

    branch_predictor_if bp_if ();

`ifdef BP_PERF_EN
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;
`endif

    branch_predictor #(.ENTRIES(64)) dut (
        .clk  (clk),
        .rst  (rst),
        .bp   (bp_if)
`ifdef BP_PERF_EN
        ,
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        pred_taken;
        logic [31:0] next_pc;
        logic        mp;
        logic [31:0] redirect;
    } exp_t;

    exp_t exp_q[$];
    int checks   = 0;
    int failures = 0;
    int exp_branches = 0;
    int exp_mispredicts = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            $display("txn %-14s pred=%0b next=0x%08h mp=%0b redir=0x%08h",
                     e.name, bp_if.if_pred_taken, bp_if.if_next_pc,
                     bp_if.mispredict, bp_if.redirect_pc);
            check32({e.name, ".pred"}, {31'd0, bp_if.if_pred_taken}, {31'd0, e.pred_taken});
            check32({e.name, ".next"}, bp_if.if_next_pc, e.next_pc);
            check32({e.name, ".mp"},   {31'd0, bp_if.mispredict}, {31'd0, e.mp});
            if (e.mp) check32({e.name, ".redir"}, bp_if.redirect_pc, e.redirect);
        end
    end

    task automatic idle_inputs();
        bp_if.ex_br_valid    = 1'b0;
        bp_if.ex_stall       = 1'b0;
        bp_if.ex_pc          = 32'd0;
        bp_if.ex_taken       = 1'b0;
        bp_if.ex_target      = 32'd0;
        bp_if.ex_pred_taken  = 1'b0;
        bp_if.ex_pred_target = 32'd0;
    endtask

    // One directed vector: drive after the edge, queue the hand-computed result.
    task automatic step(input string name, input logic [31:0] ifpc,
                        input logic v, input logic st, input logic [31:0] expc,
                        input logic tk, input logic [31:0] tgt,
                        input logic pt, input logic [31:0] ptgt,
                        input logic e_pt, input logic [31:0] e_npc,
                        input logic e_mp, input logic [31:0] e_rd);
        exp_t e;
        @(posedge clk);
        #1;
        bp_if.if_pc          = ifpc;
        bp_if.ex_br_valid    = v;
        bp_if.ex_stall       = st;
        bp_if.ex_pc          = expc;
        bp_if.ex_taken       = tk;
        bp_if.ex_target      = tgt;
        bp_if.ex_pred_taken  = pt;
        bp_if.ex_pred_target = ptgt;
        e.name = name; e.pred_taken = e_pt; e.next_pc = e_npc; e.mp = e_mp; e.redirect = e_rd;
        exp_q.push_back(e);
        if (v && !st) exp_branches++;
        if (e_mp) exp_mispredicts++;
    endtask

    task automatic lookup(input string name, input logic [31:0] ifpc,
                          input logic e_pt, input logic [31:0] e_npc);
        step(name, ifpc, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, e_pt, e_npc, 1'b0, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bp_if.if_pc = 32'h100;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        lookup("reset", 32'h100, 1'b0, 32'h104);
        // Miss+taken allocates; same-cycle lookup still sees old state
        step("alloc", 32'h100, 1, 0, 32'h100, 1, 32'h80, 0, 32'h104, 0, 32'h104, 1, 32'h80);
        lookup("after_alloc", 32'h100, 1'b1, 32'h80);
        step("tk1", 32'h100, 1, 0, 32'h100, 1, 32'h80, 1, 32'h80, 1, 32'h80, 0, 32'h0);
        step("tk2_sat", 32'h100, 1, 0, 32'h100, 1, 32'h80, 1, 32'h80, 1, 32'h80, 0, 32'h0);
        step("nt1", 32'h100, 1, 0, 32'h100, 0, 32'h80, 1, 32'h80, 1, 32'h80, 1, 32'h104);
        lookup("after_nt1", 32'h100, 1'b1, 32'h80);
        step("nt2", 32'h100, 1, 0, 32'h100, 0, 32'h80, 1, 32'h80, 1, 32'h80, 1, 32'h104);
        lookup("after_nt2", 32'h100, 1'b0, 32'h104);
        // Re-train 0x100 to weak-taken so eviction is observable
        step("retrain", 32'h100, 1, 0, 32'h100, 1, 32'h80, 0, 32'h104, 0, 32'h104, 1, 32'h80);
        lookup("alias_miss", 32'h200, 1'b0, 32'h204);
        step("evict", 32'h200, 1, 0, 32'h200, 1, 32'h300, 0, 32'h204, 0, 32'h204, 1, 32'h300);
        lookup("evicted_100", 32'h100, 1'b0, 32'h104);
        lookup("new_200", 32'h200, 1'b1, 32'h300);
        // Taken with wrong predicted target
        step("tgt_miss", 32'h200, 1, 0, 32'h200, 1, 32'h400, 1, 32'h300, 1, 32'h300, 1, 32'h400);
        lookup("new_tgt", 32'h200, 1'b1, 32'h400);
        // Stalled resolves neither redirect nor train (ctr=11 would drop to 01)
        step("stall1", 32'h200, 1, 1, 32'h200, 0, 32'h0, 1, 32'h400, 1, 32'h400, 0, 32'h0);
        step("stall2", 32'h200, 1, 1, 32'h200, 0, 32'h0, 1, 32'h400, 1, 32'h400, 0, 32'h0);
        lookup("after_stall", 32'h200, 1'b1, 32'h400);
        // Miss and not taken: no allocation
        step("miss_nt", 32'h104, 1, 0, 32'h104, 0, 32'h0, 0, 32'h108, 0, 32'h108, 0, 32'h0);
        lookup("no_alloc", 32'h104, 1'b0, 32'h108);
        // PC wrap at 2^32
        lookup("wrap_fetch", 32'hFFFF_FFFC, 1'b0, 32'h0);
        step("wrap_redir", 32'h0, 1, 0, 32'hFFFF_FFFC, 0, 32'h50, 1, 32'h50, 0, 32'h4, 1, 32'h0);

`ifdef BP_PERF_EN
        @(posedge clk);
        #1 idle_inputs();
        @(negedge clk);
        check32("perf_branches", perf_branches, exp_branches);
        check32("perf_mispredicts", perf_mispredicts, exp_mispredicts);
`endif

        // Mid-run reset with a conflicting update present: reset wins
        @(posedge clk);
        #1;
        rst = 1'b1;
        bp_if.ex_br_valid = 1'b1; bp_if.ex_pc = 32'h300; bp_if.ex_taken = 1'b1;
        bp_if.ex_target = 32'h500; bp_if.ex_pred_taken = 1'b0; bp_if.ex_pred_target = 32'h304;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
        exp_branches = 0;
        exp_mispredicts = 0;
`ifdef BP_PERF_EN
        @(negedge clk);
        check32("perf_br_rst", perf_branches, 32'd0);
        check32("perf_mp_rst", perf_mispredicts, 32'd0);
`endif
        lookup("rst_300", 32'h300, 1'b0, 32'h304);
        lookup("rst_200", 32'h200, 1'b0, 32'h204);

        // Drain the scoreboard with a bounded wait
        @(posedge clk);
        #1 idle_inputs();
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
